mc_stall_controller: RTL
========================

Name: mc_stall_controller

Overview:
- Sequencing controller for the 16-register, single-issue CPU datapath.
- Decodes the current instruction and drives every datapath control input: memtoreg, pcsrc, alusrc, regdst, regwrite, jump, lorK and alucontrol.
- Adds a PC enable plus a request/acknowledge handshake toward data memory, so loads and stores stall the datapath until memory completes.
- Detects illegal opcodes, memory timeouts and an explicit halt instruction, and counts retired instructions.

Parameters:
MAX_WAIT, 16, cycles a memory access may wait for dmem_ack before timeout (>=1)
CNT_W, 32, width of retire counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; sampled on rising edge of clk
instr  input  32  current instruction from instruction memory
zero  input  1  ALU zero flag from datapath
dmem_ack  input  1  data memory completion, valid one cycle per access
pc_en  output  1  PC register load enable (datapath PC holds when 0)
memtoreg  output  1  result mux select
pcsrc  output  1  branch-taken select
alusrc  output  1  ALU B-operand select (1 = immediate)
regdst  output  1  write-register select (1 = instr[8:5])
regwrite  output  1  register file write enable
jump  output  1  jump-target select
lorK  output  1  immediate-form select (1 = LI form)
alucontrol  output  3  ALU operation
dmem_req  output  1  data memory request
dmem_we  output  1  data memory write (valid with dmem_req)
halted  output  1  controller stopped
err  output  1  stopped because of a fault
retire_cnt  output  CNT_W  instructions retired, wraps modulo 2^CNT_W

Behaviour:
- Decode:
  - opcode = instr[31:26].
  - R-type funct = instr[3:0].
  - alucontrol codes: add 010, sub 110, and 000, or 001, slt 111.
- Decode table (signals not listed are 0):
  - R-type 000000: regwrite, regdst; alucontrol from funct (0000 add, 0001 sub, 0010 and, 0011 or, 0100 slt); any other funct is illegal.
  - LW 100011: alusrc, memtoreg, alucontrol 010, dmem_req; regwrite only in the completing cycle.
  - SW 101011: alusrc, alucontrol 010, dmem_req, dmem_we.
  - BEQ 000100: alucontrol 110, pcsrc = zero.
  - ADDI 001000: regwrite, alusrc, alucontrol 010, lorK 0.
  - LI 001111: regwrite, alusrc, alucontrol 010, lorK 1.
  - J 000010: jump.
  - HALT 111111: no datapath action; enters HALT with err = 0.
  - Any other opcode is illegal.
- States: RUN, MEM, HALT. Reset enters RUN, clears wait counter and retire_cnt, and forces halted = 0 and err = 0.
- RUN, non-memory legal instruction:
  - Decoded controls are driven combinationally from instr.
  - pc_en = 1, so the instruction retires in the same cycle.
  - Stay in RUN.
- RUN, LW/SW:
  - dmem_req = 1, pc_en = 0, regwrite = 0.
  - If dmem_ack = 1 in that same cycle, the access completes immediately (0-wait): pc_en = 1, and regwrite = 1 for LW. Stay in RUN.
  - Otherwise go to MEM with wait counter = 1.
- MEM:
  - Hold decoded controls and dmem_req / dmem_we steady; pc_en = 0, regwrite = 0.
  - On dmem_ack: pc_en = 1, regwrite = 1 for LW, return to RUN, clear wait counter.
  - Without ack: increment wait counter. When the counter reaches MAX_WAIT with no ack, go to HALT with err = 1; no completion occurs.
- RUN, illegal opcode/funct: go to HALT with err = 1; pc_en = 0 and no writes that cycle.
- RUN, HALT opcode: go to HALT with err = 0; pc_en = 0.
- HALT:
  - halted = 1 (registered, asserted from the cycle after entry).
  - All control outputs, pc_en, dmem_req and regwrite are 0.
  - Remains in HALT until reset.
- retire_cnt increments by 1 on every cycle with pc_en = 1 and wraps from all-ones to 0.
- dmem_ack outside a request (RUN with non-memory opcode, or HALT) is ignored.
- Reset mid-access (in MEM): the next state is RUN, dmem_req drops to 0 in the cycle after reset, and a pending ack is ignored.
- Outputs are combinational from state and instr, except halted, err and retire_cnt, which are registered.
- Reset values: pc_en follows decode in RUN; halted = 0, err = 0, retire_cnt = 0.

Test Plan:
- Reset, then R-type add (opcode 0, funct 0000): same cycle regwrite=1, regdst=1, alucontrol=010, pc_en=1; retire_cnt 0 -> 1 next edge.
- LW with dmem_ack asserted 3 cycles after request: dmem_req=1 for 4 cycles, pc_en=0 for first 3, then pc_en=1, regwrite=1, memtoreg=1 in the 4th; retire_cnt +1 once.
- SW with ack in same cycle: dmem_req=1, dmem_we=1, pc_en=1, regwrite=0, state stays RUN.
- BEQ with zero=1 then zero=0: pcsrc=1 / 0 respectively, alucontrol=110, pc_en=1 both cycles; LI gives lorK=1, alusrc=1, regwrite=1.
- LW with MAX_WAIT=16 and no ack: after 16 wait cycles halted=1, err=1, dmem_req=0, pc_en=0; a late ack does not change state; reset returns to RUN with err=0.
- Opcode 010101: halted=1, err=1 next cycle, no regwrite. Opcode 111111: halted=1, err=0. Preload retire_cnt near all-ones via a long run: confirms wrap to 0.

Source files
------------

// File: rtl/mc_stall_controller.sv
// mc_stall_controller
//   Sequencing controller for the 16-register single-issue CPU datapath.
//   Decodes the current instruction into datapath controls, stalls the PC
//   across data-memory accesses using a req/ack handshake, detects illegal
//   instructions, memory timeouts and HALT, and counts retired instructions.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   instr               : current instruction (held by datapath while pc_en=0)
//   zero                : ALU zero flag (BEQ condition)
//   dmem_ack            : data memory completion, one cycle per access
//   pc_en               : PC load enable; high on the cycle an instruction retires
//   memtoreg .. alucontrol : datapath control bundle
//   dmem_req, dmem_we   : data memory request / write qualifier
//   halted, err         : registered stop status, err marks a fault stop
//   retire_cnt          : retired instruction count, wraps modulo 2^CNT_W
module mc_stall_controller #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             memtoreg,
  output logic             pcsrc,
  output logic             alusrc,
  output logic             regdst,
  output logic             regwrite,
  output logic             jump,
  output logic             lorK,
  output logic [2:0]       alucontrol,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LI    = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_RUN,
    S_MEM,
    S_HALT
  } state_t;

  state_t            r_state, w_state_next;
  logic [WAIT_W-1:0] r_wait, w_wait_next;
  logic              r_halted;
  logic              r_err, w_err_next;
  logic [CNT_W-1:0]  r_retire_cnt;

  logic [5:0] w_opcode;
  logic [3:0] w_funct;
  logic       w_unused;

  // Decoded controls, independent of sequencing state
  logic       w_dec_memtoreg;
  logic       w_dec_branch;
  logic       w_dec_alusrc;
  logic       w_dec_regdst;
  logic       w_dec_regwrite;
  logic       w_dec_jump;
  logic       w_dec_lork;
  logic [2:0] w_dec_alu;
  logic       w_dec_mem;
  logic       w_dec_we;
  logic       w_dec_lw;
  logic       w_dec_illegal;
  logic       w_dec_halt;

  assign w_opcode = instr[31:26];
  assign w_funct  = instr[3:0];
  assign w_unused = ^instr[25:4];

  // Instruction decode
  always_comb begin
    w_dec_memtoreg = 1'b0;
    w_dec_branch   = 1'b0;
    w_dec_alusrc   = 1'b0;
    w_dec_regdst   = 1'b0;
    w_dec_regwrite = 1'b0;
    w_dec_jump     = 1'b0;
    w_dec_lork     = 1'b0;
    w_dec_alu      = '0;
    w_dec_mem      = 1'b0;
    w_dec_we       = 1'b0;
    w_dec_lw       = 1'b0;
    w_dec_illegal  = 1'b0;
    w_dec_halt     = 1'b0;
    case (w_opcode)
      OP_RTYPE: begin
        w_dec_regwrite = 1'b1;
        w_dec_regdst   = 1'b1;
        case (w_funct)
          4'b0000: w_dec_alu = ALU_ADD;
          4'b0001: w_dec_alu = ALU_SUB;
          4'b0010: w_dec_alu = ALU_AND;
          4'b0011: w_dec_alu = ALU_OR;
          4'b0100: w_dec_alu = ALU_SLT;
          default: w_dec_illegal = 1'b1;
        endcase
      end
      OP_LW: begin
        w_dec_alusrc   = 1'b1;
        w_dec_memtoreg = 1'b1;
        w_dec_alu      = ALU_ADD;
        w_dec_mem      = 1'b1;
        w_dec_lw       = 1'b1;
      end
      OP_SW: begin
        w_dec_alusrc = 1'b1;
        w_dec_alu    = ALU_ADD;
        w_dec_mem    = 1'b1;
        w_dec_we     = 1'b1;
      end
      OP_BEQ: begin
        w_dec_alu    = ALU_SUB;
        w_dec_branch = 1'b1;
      end
      OP_ADDI: begin
        w_dec_regwrite = 1'b1;
        w_dec_alusrc   = 1'b1;
        w_dec_alu      = ALU_ADD;
      end
      OP_LI: begin
        w_dec_regwrite = 1'b1;
        w_dec_alusrc   = 1'b1;
        w_dec_alu      = ALU_ADD;
        w_dec_lork     = 1'b1;
      end
      OP_J:    w_dec_jump    = 1'b1;
      OP_HALT: w_dec_halt    = 1'b1;
      default: w_dec_illegal = 1'b1;
    endcase
  end

  // Sequencing: next state and control outputs
  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait;
    w_err_next   = r_err;
    pc_en        = 1'b0;
    memtoreg     = 1'b0;
    pcsrc        = 1'b0;
    alusrc       = 1'b0;
    regdst       = 1'b0;
    regwrite     = 1'b0;
    jump         = 1'b0;
    lorK         = 1'b0;
    alucontrol   = '0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_dec_illegal) begin
          w_state_next = S_HALT;
          w_err_next   = 1'b1;
        end else if (w_dec_halt) begin
          w_state_next = S_HALT;
        end else if (w_dec_mem) begin
          memtoreg   = w_dec_memtoreg;
          alusrc     = w_dec_alusrc;
          alucontrol = w_dec_alu;
          dmem_req   = 1'b1;
          dmem_we    = w_dec_we;
          if (dmem_ack) begin
            // zero-wait access completes in the request cycle
            pc_en    = 1'b1;
            regwrite = w_dec_lw;
          end else begin
            w_state_next = S_MEM;
            w_wait_next  = WAIT_W'(1);
          end
        end else begin
          pc_en      = 1'b1;
          memtoreg   = w_dec_memtoreg;
          pcsrc      = w_dec_branch & zero;
          alusrc     = w_dec_alusrc;
          regdst     = w_dec_regdst;
          regwrite   = w_dec_regwrite;
          jump       = w_dec_jump;
          lorK       = w_dec_lork;
          alucontrol = w_dec_alu;
        end
      end
      S_MEM: begin
        // instr is held by the stalled PC, so decode stays valid here
        memtoreg   = w_dec_memtoreg;
        alusrc     = w_dec_alusrc;
        alucontrol = w_dec_alu;
        dmem_req   = 1'b1;
        dmem_we    = w_dec_we;
        if (dmem_ack) begin
          pc_en        = 1'b1;
          regwrite     = w_dec_lw;
          w_state_next = S_RUN;
          w_wait_next  = '0;
        end else if (r_wait >= WAIT_LIMIT) begin
          w_state_next = S_HALT;
          w_err_next   = 1'b1;
          w_wait_next  = '0;
        end else begin
          w_wait_next = r_wait + WAIT_W'(1);
        end
      end
      default: begin
        w_state_next = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_RUN;
      r_wait       <= '0;
      r_halted     <= 1'b0;
      r_err        <= 1'b0;
      r_retire_cnt <= '0;
    end else begin
      r_state  <= w_state_next;
      r_wait   <= w_wait_next;
      r_halted <= (w_state_next == S_HALT);
      r_err    <= w_err_next;
      if (pc_en) begin
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      end
    end
  end

  assign halted     = r_halted;
  assign err        = r_err;
  assign retire_cnt = r_retire_cnt;

endmodule
